// File: rtl/data_memory_copy_engine.sv
// Word-addressed data memory with a CPU load/store port, a combinational debug read port
// and an overlap-safe block-copy engine. Optional fill mode is enabled by defining DM_FILL_EN.
module data_memory_copy_engine #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  input  logic                  copy_start,
  input  logic [31:0]           copy_src,
  input  logic [31:0]           copy_dst,
  input  logic [LEN_W-1:0]      copy_len,
`ifdef DM_FILL_EN
  input  logic                  copy_fill,
`endif
  output logic                  copy_busy,
  output logic                  copy_done,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  output logic [DATA_W-1:0]     ext_data
);

  localparam int               DEPTH     = 2 ** DM_ADDRESS;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_e;

  state_e                state_q, state_d;
  logic [DM_ADDRESS-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]      len_q, len_d, cnt_q, cnt_d;
  logic                  desc_q, desc_d;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DM_ADDRESS-1:0] src_in, dst_in, offset, rd_addr, wr_addr;
  logic [LEN_W-1:0]      len_clamped, rem;
  logic [LEN_W:0]        src_plus_len;
  logic                  overlap, beat, last_beat;
  logic                  beat_fill;
  logic [DATA_W-1:0]     beat_fill_data, beat_data;

`ifdef DM_FILL_EN
  logic                  fill_q, fill_d;
  logic [DATA_W-1:0]     fill_data_q, fill_data_d;
  assign beat_fill      = fill_q;
  assign beat_fill_data = fill_data_q;
`else
  assign beat_fill      = 1'b0;
  assign beat_fill_data = '0;
`endif

  assign src_in       = copy_src[DM_ADDRESS-1:0];
  assign dst_in       = copy_dst[DM_ADDRESS-1:0];
  assign len_clamped  = (copy_len > DEPTH_LEN) ? DEPTH_LEN : copy_len;
  // Overlap test uses unwrapped src+len so a destination just above the source copies top-down.
  assign src_plus_len = (LEN_W+1)'(src_in) + (LEN_W+1)'(len_clamped);
  assign overlap      = (dst_in > src_in) && ((LEN_W+1)'(dst_in) < src_plus_len);

  assign rem       = len_q - cnt_q - LEN_W'(1);
  assign offset    = desc_q ? rem[DM_ADDRESS-1:0] : cnt_q[DM_ADDRESS-1:0];
  assign rd_addr   = src_q + offset;
  assign wr_addr   = dst_q + offset;
  assign beat      = (state_q == COPY) && !mem_write;
  assign last_beat = (cnt_q == len_q - LEN_W'(1));
  assign beat_data = beat_fill ? beat_fill_data : mem[rd_addr];

  // NOTE: every next-state signal takes its held value first, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
`ifdef DM_FILL_EN
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (copy_start) begin
          src_d   = src_in;
          dst_d   = dst_in;
          len_d   = len_clamped;
          cnt_d   = '0;
          state_d = (copy_len == '0) ? DONE : COPY;
`ifdef DM_FILL_EN
          fill_d      = copy_fill;
          fill_data_d = copy_src[DATA_W-1:0];
          desc_d      = overlap && !copy_fill;
`else
          desc_d      = overlap;
`endif
        end
      end
      COPY: begin
        if (beat) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
`ifdef DM_FILL_EN
      fill_q      <= 1'b0;
      fill_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
`ifdef DM_FILL_EN
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
`endif
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (mem_write)  mem[a]       <= wd;
    else if (beat)  mem[wr_addr] <= beat_data;
  end

  assign rd        = mem_read ? mem[a] : '0;
  assign ext_data  = mem[ext_addr];
  assign copy_busy = (state_q == COPY);
  assign copy_done = (state_q == DONE);

  logic unused_bits;
  assign unused_bits = ^{copy_src[31:DM_ADDRESS], copy_dst[31:DM_ADDRESS],
                         rem[LEN_W-1:DM_ADDRESS], cnt_q[LEN_W-1:DM_ADDRESS]};

endmodule
